// File: rtl/fare_meter.sv
// fare_meter: taxi trip fare accumulator with distance/wait charging and idle detection
module fare_meter #(
  parameter int DW        = 32,
  parameter int START_FEE = 1000,
  parameter int BASE_DIST = 30,
  parameter int DIST_FEE  = 26,
  parameter int WAIT_FEE  = 5,
  parameter int IDLE_CNT  = 100
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          stop,
  input  logic          km_pulse,
  input  logic [DW-1:0] wait_units,
  output logic          waiting,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] fare,
  output logic [DW-1:0] distance
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam int IW = $clog2(IDLE_CNT + 2);
  localparam logic [DW-1:0] MAX = '1;
  localparam logic [DW-1:0] SF = DW'(START_FEE);
  localparam logic [DW-1:0] BD = DW'(BASE_DIST);
  localparam logic [DW-1:0] DF = DW'(DIST_FEE);
  localparam logic [DW-1:0] WF = DW'(WAIT_FEE);
  localparam logic [IW-1:0] IC = IW'(IDLE_CNT);
  state_t state;
  logic [DW-1:0] wait_prev, dist_nx, fare_w, fare_nx;
  logic [DW:0] sum_w, sum_d;
  logic [IW-1:0] idle_cnt, idle_nx;
  logic wait_hit, dist_hit, fee_hit;
  // Next trip values for a RUN cycle; each fee is added one bit wide and clamped in turn
  always_comb begin
    wait_hit = wait_units != wait_prev;
    dist_hit = km_pulse && distance != MAX;
    dist_nx = dist_hit ? distance + 1'b1 : distance;
    fee_hit = dist_hit && dist_nx > BD;
    sum_w = {1'b0, fare} + (wait_hit ? {1'b0, WF} : '0);
    fare_w = sum_w[DW] ? MAX : sum_w[DW-1:0];
    sum_d = {1'b0, fare_w} + (fee_hit ? {1'b0, DF} : '0);
    fare_nx = sum_d[DW] ? MAX : sum_d[DW-1:0];
    idle_nx = km_pulse ? '0 : (idle_cnt == IC ? idle_cnt : idle_cnt + 1'b1);
  end
  // Trip FSM with registered outputs; the stop cycle is still a charged RUN cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      fare <= '0;
      distance <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      waiting <= 1'b0;
      idle_cnt <= '0;
      wait_prev <= '0;
    end else begin
      wait_prev <= wait_units;
      done <= 1'b0;
      if (state == RUN) begin
        fare <= fare_nx;
        distance <= dist_nx;
        idle_cnt <= idle_nx;
        if (stop) begin
          state <= DONE;
          busy <= 1'b0;
          done <= 1'b1;
          waiting <= 1'b0;
        end else begin
          waiting <= idle_nx == IC;
        end
      end else if (start) begin
        state <= RUN;
        busy <= 1'b1;
        fare <= SF;
        distance <= '0;
        idle_cnt <= '0;
        waiting <= IC == '0;
      end
    end
  end
endmodule

// File: tb/tb_fare_meter.sv
// tb_fare_meter: random and directed checks of fare_meter against a trip-level model
module tb_fare_meter;
  logic clk = 0, rst_n = 0, start = 0, stop = 0, km = 0;
  logic [31:0] wu = 0;
  logic waiting, busy, done;
  logic [31:0] fare, distance;
  logic s_start = 0, s_km = 0;
  logic [11:0] s_wu = 0;
  logic s_waiting, s_busy, s_done;
  logic [11:0] s_fare, s_distance;
  int checks = 0, errors = 0;
  bit m_run, m_done;
  longint m_fare, m_dist, m_add;
  int m_since;
  logic [31:0] m_prev;
  localparam longint MAXV = 64'hFFFF_FFFF;

  fare_meter dut (.clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .km_pulse(km),
    .wait_units(wu), .waiting(waiting), .busy(busy), .done(done), .fare(fare), .distance(distance));

  fare_meter #(.DW(12), .START_FEE(4000), .BASE_DIST(0), .DIST_FEE(50)) sat (.clk(clk),
    .rst_n(rst_n), .start(s_start), .stop(1'b0), .km_pulse(s_km), .wait_units(s_wu),
    .waiting(s_waiting), .busy(s_busy), .done(s_done), .fare(s_fare), .distance(s_distance));

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Trip-level reference: a trip is open or closed, fees are plain sums clamped to the max
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_run = 0; m_done = 0; m_fare = 0; m_dist = 0; m_since = 0; m_prev = 0;
    end else begin
      if (m_run) begin
        m_add = (wu != m_prev) ? 5 : 0;
        if (km && m_dist < MAXV) begin
          m_dist++;
          if (m_dist > 30) m_add += 26;
        end
        m_fare = (m_fare + m_add > MAXV) ? MAXV : m_fare + m_add;
        m_since = km ? 0 : (m_since < 1000 ? m_since + 1 : m_since);
        m_done = stop;
        if (stop) m_run = 0;
      end else begin
        m_done = 0;
        if (start) begin
          m_run = 1; m_fare = 1000; m_dist = 0; m_since = 0;
        end
      end
      m_prev = wu;
    end
  end

  // Compare every output with the model on each falling edge
  always @(negedge clk) begin
    chk("busy", longint'(busy), longint'(m_run));
    chk("done", longint'(done), longint'(m_done));
    chk("waiting", longint'(waiting), longint'(m_run && m_since >= 100));
    chk("fare", longint'(fare), m_fare);
    chk("distance", longint'(distance), m_dist);
  end

  task automatic cyc(input logic s, input logic p, input logic k, input logic d);
    start = s; stop = p; km = k; wu = wu + {31'd0, d};
    @(posedge clk); #1;
    start = 0; stop = 0; km = 0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_fare", longint'(fare), 0);
    chk("rst_dist", longint'(distance), 0);
    chk("rst_busy", longint'(busy), 0);
    chk("rst_done", longint'(done), 0);
    chk("rst_wait", longint'(waiting), 0);
    rst_n = 1;
    repeat (3) cyc(0, 0, 1, 1);
    chk("idle_fare", longint'(fare), 0);
    chk("idle_busy", longint'(busy), 0);
    chk("idle_dist", longint'(distance), 0);
    cyc(1, 0, 0, 0);
    chk("start_busy", longint'(busy), 1);
    chk("start_fare", longint'(fare), 1000);
    repeat (99) cyc(0, 0, 0, 0);
    chk("wait_99", longint'(waiting), 0);
    cyc(0, 0, 0, 0);
    chk("wait_100", longint'(waiting), 1);
    repeat (3) cyc(0, 0, 0, 1);
    chk("wait_fee", longint'(fare), 1015);
    cyc(0, 0, 1, 0);
    chk("wait_drop", longint'(waiting), 0);
    chk("wait_dist", longint'(distance), 1);
    cyc(0, 1, 0, 0);
    chk("stop_done", longint'(done), 1);
    chk("stop_busy", longint'(busy), 0);
    chk("stop_fare", longint'(fare), 1015);
    cyc(0, 0, 0, 0);
    chk("done_pulse", longint'(done), 0);
    repeat (3) cyc(0, 0, 1, 1);
    chk("held_fare", longint'(fare), 1015);
    chk("held_dist", longint'(distance), 1);
    cyc(1, 1, 0, 0);
    chk("restart_busy", longint'(busy), 1);
    chk("restart_fare", longint'(fare), 1000);
    chk("restart_dist", longint'(distance), 0);
    repeat (30) cyc(0, 0, 1, 0);
    chk("base_fare", longint'(fare), 1000);
    chk("base_dist", longint'(distance), 30);
    cyc(0, 0, 1, 0);
    chk("pulse31", longint'(fare), 1026);
    repeat (4) cyc(0, 0, 1, 0);
    chk("pulse35", longint'(fare), 1130);
    chk("dist35", longint'(distance), 35);
    cyc(0, 1, 0, 0);
    cyc(1, 0, 0, 0);
    repeat (30) cyc(0, 0, 1, 0);
    cyc(0, 0, 1, 1);
    chk("both_fees", longint'(fare), 1031);
    rst_n = 0;
    #1;
    chk("mid_rst_fare", longint'(fare), 0);
    chk("mid_rst_dist", longint'(distance), 0);
    chk("mid_rst_busy", longint'(busy), 0);
    @(posedge clk); #1;
    rst_n = 1;
    cyc(0, 0, 1, 1);
    chk("post_rst_busy", longint'(busy), 0);
    chk("post_rst_fare", longint'(fare), 0);
    wu = 32'hFFFF_FFF0;
    cyc(1, 0, 0, 0);
    for (int seg = 0; seg < 30; seg++) begin
      int mode;
      mode = $urandom_range(0, 2);
      repeat (100) begin
        logic s, p, k, d;
        s = $urandom_range(0, 39) == 0;
        p = $urandom_range(0, 149) == 0;
        k = mode == 0 ? 1'b0 : mode == 1 ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 119) == 0);
        d = $urandom_range(0, 2) == 0;
        cyc(s, p, k, d);
      end
    end
    s_start = 1;
    @(posedge clk); #1;
    s_start = 0;
    chk("sat_start", longint'(s_fare), 4000);
    s_km = 1;
    @(posedge clk); #1;
    chk("sat_p1", longint'(s_fare), 4050);
    @(posedge clk); #1;
    chk("sat_p2", longint'(s_fare), 4095);
    @(posedge clk); #1;
    chk("sat_p3", longint'(s_fare), 4095);
    chk("sat_dist", longint'(s_distance), 3);
    s_km = 0;
    chk("sat_busy", longint'(s_busy), 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fare_meter.md
# fare_meter

Trip fare accumulator for the taxi meter. It sits directly downstream of the wait-duration counter: it consumes that counter's running 6 s wait-unit count and the wheel distance pulses, and produces the fare, the trip distance and trip status for the display stage. It also generates the `waiting` level that enables the wait-duration counter upstream, which closes the loop between the two blocks.

## Interface
Parameters:
- `DW`, 32: width of the fare, distance and wait-count datapaths.
- `START_FEE`, 1000: flag-fall fare in fen, covering the base distance.
- `BASE_DIST`, 30: distance in 0.1 km units included in `START_FEE`.
- `DIST_FEE`, 26: fen charged per 0.1 km beyond `BASE_DIST`.
- `WAIT_FEE`, 5: fen charged per 6 s wait unit.
- `IDLE_CNT`, 100: consecutive RUN cycles without a `km_pulse` before `waiting` asserts.

Ports:
- `clk`, input, 1: single clock. All logic is on the rising edge.
- `rst_n`, input, 1: asynchronous active-low reset.
- `start`, input, 1: trip-start request, one cycle.
- `stop`, input, 1: trip-end request, one cycle.
- `km_pulse`, input, 1: one-cycle pulse per 0.1 km travelled.
- `wait_units`, input, DW: running wait-unit count from the wait-duration counter, synchronous to `clk`.
- `waiting`, output, 1: vehicle is stationary during a trip. Drives the enable of the wait-duration counter.
- `busy`, output, 1: trip in progress (state RUN).
- `done`, output, 1: one-cycle pulse when a trip ends.
- `fare`, output, DW: current or final fare in fen.
- `distance`, output, DW: trip distance in 0.1 km units.

## Operation
- States:
  - IDLE is the reset state.
  - RUN is an active trip.
  - DONE holds the final fare and distance.
- Transitions:
  - IDLE or DONE → RUN on `start`.
  - RUN → DONE on `stop`.
  - `start` while in RUN is ignored.
  - `stop` while in IDLE or DONE is ignored.
  - `start` and `stop` in the same cycle: in IDLE or DONE, `start` wins; in RUN, `stop` wins.
- Entering RUN loads the trip registers: `fare` = `START_FEE`, `distance` = 0, idle counter = 0.
- `wait_prev` captures `wait_units` every cycle, in all states.
- Wait charge:
  - In RUN, any cycle where `wait_units` ≠ `wait_prev` adds `WAIT_FEE` once.
  - The upstream counter advances by at most 1 per cycle, so at most one unit is charged per cycle.
  - Wrap of the upstream count from all-ones to 0 counts as a change.
- Distance charge:
  - In RUN, each `km_pulse` increments `distance`.
  - `DIST_FEE` is added only when the new distance is greater than `BASE_DIST`.
  - Example: the 31st pulse is the first one charged.
- When a wait change and a charged `km_pulse` occur in the same cycle, both fees are added in that cycle.
- Saturation:
  - `fare` saturates at 2^DW−1.
  - `distance` saturates at 2^DW−1; pulses arriving at saturation add no fee.
  - Sums are computed one bit wider than DW, then clamped.
- Idle counter:
  - Clears on `km_pulse` and on entry to RUN.
  - Otherwise increments in RUN, saturating at `IDLE_CNT`.
  - `waiting` = RUN and counter == `IDLE_CNT`.
- Leaving RUN:
  - `waiting` and `busy` drop.
  - `fare` and `distance` hold their values until the next `start`.
- Reset (`rst_n` low at any time, including mid-trip): state IDLE, and `fare`, `distance`, `busy`, `done`, `waiting`, idle counter and `wait_prev` all go to 0 immediately.

## Timing
- All outputs are registered. Every output is 0 in reset.
- `start` sampled at edge N: at N+1, `busy` = 1 and `fare` = `START_FEE`.
- `stop` sampled at edge N: at N+1, `busy` = 0 and `done` = 1. At N+2, `done` = 0.
- `km_pulse` or a wait-count change sampled at edge N is reflected in `fare` and `distance` at N+1. Fee latency is one cycle.
- `waiting` asserts on the edge where the idle counter reaches `IDLE_CNT`. That is `IDLE_CNT` cycles after the last `km_pulse` or `start`.
- `waiting` deasserts one cycle after a `km_pulse`.
- Changes to `wait_units` during the cycle in which `start` is sampled are not charged.

## Test plan
- Reset with default parameters:
  - With `rst_n` low, all outputs are 0.
  - After release, with no `start`, pulses and `wait_units` changes have no effect: `fare` = 0, `busy` = 0.
- Start plus distance:
  - Apply `start`, then 30 `km_pulse` → `fare` = 1000, `distance` = 30.
  - 31st pulse → `fare` = 1026.
  - 35th pulse → `fare` = 1130.
- Waiting:
  - After `start`, apply no pulses for 100 cycles → `waiting` rises exactly at cycle 100.
  - Step `wait_units` 3 times → `fare` = 1015.
  - One `km_pulse` → `waiting` = 0 on the next cycle.
- Simultaneous events:
  - With `distance` = 30, present `km_pulse` and a `wait_units` change in the same cycle → `fare` increases by 31 in one cycle.
- Stop and restart:
  - `stop` → `done` high for exactly 1 cycle, `busy` = 0, `fare` held.
  - Later pulses leave `fare` and `distance` unchanged.
  - `start` and `stop` together in DONE → RUN with `fare` = 1000, `distance` = 0.
  - Reset mid-trip → all outputs 0, state IDLE.
- Saturation with `DW` = 12:
  - `START_FEE` = 4000, `BASE_DIST` = 0, `DIST_FEE` = 50 → after 2 pulses `fare` = 4095 and holds at 4095 on further pulses.
